// File: rtl/mantissa_multiplier_seq.sv
// Sequential shift-add multiplier for normalized 1.M mantissas.
// Produces one partial-product step per clock and a truncated, renormalized 1.M result with sticky.
module mantissa_multiplier_seq #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] norm_a_mant,
    input  logic [WIDTH-1:0] norm_b_mant,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_mant,
    output logic             exp_inc,
    output logic             sticky
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_NORM = 2'd2
    } state_t;

    // Renormalize a raw product: returns {exp_inc, sticky, mantissa}.
    function automatic logic [WIDTH+1:0] normalize(input logic [PW-1:0] p);
        logic [WIDTH-1:0] mant;
        logic             inc;
        logic             stk;
        if (p[PW-1] == 1'b1) begin
            mant = p[PW-1 -: WIDTH];
            inc  = 1'b1;
            stk  = |p[WIDTH-1:0];
        end else begin
            mant = p[PW-2 -: WIDTH];
            inc  = 1'b0;
            stk  = |p[WIDTH-2:0];
        end
        return {inc, stk, mant};
    endfunction

    state_t           state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             exp_inc_q, exp_inc_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH+1:0] norm_s;
    logic [PW-1:0]    addend_s;

    // Multiplicand is kept pre-shifted and the multiplier shifted down, so
    // b_q[0] is the bit b[cnt] and a_q is a << cnt without a barrel shifter.
    always_comb begin
        if (b_q[0] == 1'b1) begin
            addend_s = a_q;
        end else begin
            addend_s = {PW{1'b0}};
        end
        norm_s = normalize(acc_q);
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        prod_d    = prod_q;
        exp_inc_d = exp_inc_q;
        sticky_d  = sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (start == 1'b1) begin
                    a_d     = {{WIDTH{1'b0}}, norm_a_mant};
                    b_d     = norm_b_mant;
                    acc_d   = {PW{1'b0}};
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + addend_s;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_NORM: begin
                prod_d    = norm_s[WIDTH-1:0];
                sticky_d  = norm_s[WIDTH];
                exp_inc_d = norm_s[WIDTH+1];
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= {PW{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            acc_q     <= {PW{1'b0}};
            cnt_q     <= CNT_ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prod_q    <= {WIDTH{1'b0}};
            exp_inc_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            prod_q    <= prod_d;
            exp_inc_q <= exp_inc_d;
            sticky_q  <= sticky_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign product_mant = prod_q;
    assign exp_inc      = exp_inc_q;
    assign sticky       = sticky_q;

endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// Directed bench for mantissa_multiplier_seq: latency, handshake, reset abort and results.
module tb_mantissa_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] a;
    logic [23:0] b;
    logic        busy;
    logic        done;
    logic [23:0] product_mant;
    logic        exp_inc;
    logic        sticky;

    int n_pass  = 0;
    int n_total = 0;

    mantissa_multiplier_seq #(.WIDTH(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .norm_a_mant  (a),
        .norm_b_mant  (b),
        .busy         (busy),
        .done         (done),
        .product_mant (product_mant),
        .exp_inc      (exp_inc),
        .sticky       (sticky)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic ref_model(input logic [23:0] x, input logic [23:0] y,
                             output logic [23:0] m, output logic e, output logic s);
        logic [47:0] p;
        p = {24'd0, x} * {24'd0, y};
        if (p[47]) begin
            m = p[47:24]; e = 1'b1; s = |p[23:0];
        end else begin
            m = p[46:23]; e = 1'b0; s = |p[22:0];
        end
    endtask

    // Waits up to 40 edges for done; n = edges waited, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic launch(input logic [23:0] x, input logic [23:0] y);
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [23:0] m, input logic e, input logic s);
        check_eq({tag, "_mant"}, {40'd0, product_mant}, {40'd0, m});
        check_eq({tag, "_exp_inc"}, {63'd0, exp_inc}, {63'd0, e});
        check_eq({tag, "_sticky"}, {63'd0, sticky}, {63'd0, s});
        check_eq({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic directed(input string tag, input logic [23:0] x, input logic [23:0] y,
                            input logic [23:0] m, input logic e, input logic s);
        int n;
        launch(x, y);
        wait_done(n);
        check_eq({tag, "_latency"}, 64'(n), 64'd25);
        check_result(tag, m, e, s);
        @(posedge clk); #1;
        check_eq({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_mant_hold"}, {40'd0, product_mant}, {40'd0, m});
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_mant"}, {40'd0, product_mant}, 64'd0);
        check_eq({tag, "_exp_inc"}, {63'd0, exp_inc}, 64'd0);
        check_eq({tag, "_sticky"}, {63'd0, sticky}, 64'd0);
    endtask

    initial begin
        int          n;
        int          dones;
        logic        busy_ok;
        logic [23:0] va [8];
        logic [23:0] vb [8];
        logic [23:0] em;
        logic        ee;
        logic        es;

        rst = 1'b1; start = 1'b0; a = 24'd0; b = 24'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("reset");

        directed("one_x_one", 24'h800000, 24'h800000, 24'h800000, 1'b0, 1'b0);
        directed("c15_x_c15", 24'hC00000, 24'hC00000, 24'h900000, 1'b1, 1'b0);
        directed("max_x_max", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1, 1'b1);
        directed("lsb_sticky", 24'h800001, 24'h800001, 24'h800002, 1'b0, 1'b1);
        directed("unnorm", 24'h400000, 24'h400000, 24'h200000, 1'b0, 1'b0);

        // start while busy must be ignored; operand changes must not leak in
        launch(24'hC00000, 24'hC00000);
        busy_ok = 1'b1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                n = i;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (i == 4) begin
                start = 1'b1; a = 24'h800000; b = 24'h800000;
            end
        end
        check_eq("ignore_start_busy", {63'd0, busy_ok}, 64'd1);
        check_eq("ignore_start_latency", 64'(n), 64'd25);
        check_result("ignore_start", 24'h900000, 1'b1, 1'b0);
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check_eq("ignore_start_no_extra_done", 64'(dones), 64'd0);

        // reset in mid-flight abandons the operation
        launch(24'hFFFFFF, 24'hFFFFFF);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("abort");
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 64'd0);
        directed("after_abort", 24'h800000, 24'h800000, 24'h800000, 1'b0, 1'b0);

        // back-to-back random operands, restarting on each done cycle
        for (int j = 0; j < 8; j++) begin
            va[j] = 24'($urandom) | 24'h800000;
            vb[j] = 24'($urandom) | 24'h800000;
        end
        launch(va[0], vb[0]);
        for (int j = 0; j < 8; j++) begin
            wait_done(n);
            check_eq("b2b_spacing", 64'(n), (j == 0) ? 64'd25 : 64'd26);
            ref_model(va[j], vb[j], em, ee, es);
            check_result("b2b", em, ee, es);
            if (j < 7) begin
                start = 1'b1; a = va[j+1]; b = vb[j+1];
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
